wb_stage_buf: RTL and testbench
===============================

Name: wb_stage_buf

Overview:
- Parametrised successor to the single-register write-back stage of the 16-bit MIPS pipeline.
- Selects the write-back result from ALU, memory, link or immediate sources. Applies load extension to memory data.
- Buffers up to two instructions in an output register plus a skid entry, so register-file back-pressure does not drop results.
- Drives the register-file write port, exports a forwarding tap for the execute stage and counts retired instructions.

Parameters:
DATA_W, 16, datapath width (≥ 8)
REG_AW, 3, register address width
CNT_W, 16, retire counter width

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset)
in_valid  input  1  memory stage presents an instruction
in_ready  output  1  stage can accept; registered, equals "skid entry empty"
in_wb_sel  input  2  00 ALU, 01 MEM, 10 LINK, 11 IMM
in_alu  input  DATA_W  ALU result
in_mem  input  DATA_W  data-memory read data
in_link  input  DATA_W  return address
in_imm  input  DATA_W  immediate
in_ld_mode  input  2  00 word, 01 byte signed, 10 byte unsigned, 11 treated as word
in_rd  input  REG_AW  destination register
in_we  input  1  instruction writes a register
flush  input  1  discard all buffered and incoming instructions
rf_ready  input  1  register file accepts the write this cycle
rf_we  output  1  register write enable
rf_waddr  output  REG_AW  write address
rf_wdata  output  DATA_W  write data
fwd_valid  output  1  forwarding tap valid
fwd_addr  output  REG_AW  forwarding register
fwd_data  output  DATA_W  forwarding data
retire_count  output  CNT_W  retired-instruction counter

Behaviour:
- Reset (reset=0, async): both entries invalid; in_ready=1; rf_we=0, rf_waddr=0, rf_wdata=0; fwd_valid=0, fwd_addr=0, fwd_data=0; retire_count=0.
- Result select is combinational at the input and is stored in the entry:
  - wb_sel=01, ld_mode 01: sign-extend in_mem[7:0].
  - wb_sel=01, ld_mode 10: zero-extend in_mem[7:0].
  - wb_sel=01, ld_mode 00/11: in_mem unchanged.
  - ld_mode is ignored for other sources.
- Each entry stores {valid, we_eff, rd, data}. we_eff = in_we & (in_rd != 0); writes to r0 are suppressed but the instruction still retires.
- Accept: in_valid & in_ready & ~flush.
- Output entry OUT drives the write port:
  - rf_we = OUT.valid & OUT.we_eff
  - rf_waddr = OUT.rd; rf_wdata = OUT.data
- Retire: OUT.valid & rf_ready. OUT advances on retire or when OUT is empty.
- Latency: an accepted instruction appears in OUT on the next edge if OUT is empty or retiring; otherwise it goes to SKID.
- Refill on each edge:
  - SKID occupied: SKID moves into OUT when OUT frees.
  - Otherwise: the accepted input moves into OUT.
  - An input accepted while SKID moves goes into SKID.
  - Order is preserved: SKID is always older than the input.
- in_ready is deasserted the cycle after SKID fills and reasserts the cycle after SKID drains.
- Full case: OUT and SKID valid, rf_ready=0. Nothing changes. in_valid is ignored and must be held by the upstream stage.
- Forwarding tap:
  - Presents the youngest valid entry (SKID if valid, else OUT).
  - fwd_valid = that entry's valid & we_eff.
  - fwd_addr and fwd_data hold the last values when fwd_valid=0.
- Flush:
  - On the edge, OUT and SKID are cleared and the concurrent input is dropped.
  - A retire occurring in the same cycle still counts, and its rf_we is still asserted during that cycle.
- retire_count: +1 per retire, wraps modulo 2^CNT_W.
- Reset asserted mid-operation clears all state immediately, without waiting for clk.

Test Plan:
- Reset, then rf_ready=1. Send ALU=0x1234, rd=3, we=1 → one cycle later rf_we=1, waddr=3, wdata=0x1234; retire_count=1.
- wb_sel=MEM, in_mem=0x00F0: ld_mode=01 → wdata=0xFFF0; ld_mode=10 → 0x00F0; ld_mode=11 → 0x00F0.
- rf_ready=0, send A(rd1), B(rd2), C → A in OUT, B in SKID, in_ready=0, C held. fwd shows rd=2. Set rf_ready=1 → writes A, B, C in order; count=3.
- Send rd=0, we=1, data=0x5555 → rf_we=0, fwd_valid=0, retire_count increments.
- Fill both entries, assert flush with in_valid=1 and rf_ready=1 → OUT written and counted this cycle; next cycle no valid entries, the incoming instruction is lost, in_ready=1.
- Pull reset low asynchronously mid-burst → all outputs 0 before the next clk edge. Preset count to 0xFFFF by 65535 retires, one more retire → retire_count=0x0000.

Source files
------------

// File: rtl/wb_stage_buf.sv
// Write-back stage with result select, load extension, output register
// plus one skid entry, register-file write port, forwarding tap, retire counter.
module wb_stage_buf #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_wb_sel,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_mem,
    input  logic [DATA_W-1:0] in_link,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [1:0]        in_ld_mode,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_we,
    input  logic              flush,
    input  logic              rf_ready,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_addr,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  retire_count
);

    typedef struct packed {
        logic              valid;
        logic              we;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t            out_q, out_d;
    entry_t            skid_q, skid_d;
    entry_t            in_e;
    entry_t            young;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [REG_AW-1:0] fwd_addr_q, fwd_addr_d;
    logic [DATA_W-1:0] fwd_data_q, fwd_data_d;
    logic [DATA_W-1:0] sel_data;
    logic              accept;
    logic              retire;
    logic              out_free;

    always_comb begin
        sel_data = in_alu;
        case (in_wb_sel)
            2'b00: sel_data = in_alu;
            2'b01: begin
                case (in_ld_mode)
                    2'b01:   sel_data = DATA_W'($signed(in_mem[7:0]));
                    2'b10:   sel_data = DATA_W'(in_mem[7:0]);
                    default: sel_data = in_mem;
                endcase
            end
            2'b10:   sel_data = in_link;
            default: sel_data = in_imm;
        endcase
    end

    // r0 writes are dropped here but the entry still retires
    always_comb begin
        in_e.valid = 1'b1;
        in_e.we    = in_we & (in_rd != '0);
        in_e.rd    = in_rd;
        in_e.data  = sel_data;
    end

    assign accept   = in_valid & ~skid_q.valid & ~flush;
    assign retire   = out_q.valid & rf_ready;
    assign out_free = ~out_q.valid | retire;

    always_comb begin
        out_d  = out_q;
        skid_d = skid_q;
        if (flush) begin
            out_d.valid  = 1'b0;
            skid_d.valid = 1'b0;
        end else if (out_free) begin
            if (skid_q.valid) begin
                out_d        = skid_q;
                skid_d.valid = 1'b0;
                if (accept) begin
                    skid_d = in_e;
                end
            end else if (accept) begin
                out_d = in_e;
            end else begin
                out_d.valid = 1'b0;
            end
        end else if (accept) begin
            skid_d = in_e;
        end
    end

    always_comb begin
        cnt_d = cnt_q + CNT_W'(retire);
    end

    // tap shows the youngest entry; address/data stick when nothing forwards
    always_comb begin
        young      = skid_q.valid ? skid_q : out_q;
        fwd_valid  = young.valid & young.we;
        fwd_addr_d = fwd_valid ? young.rd : fwd_addr_q;
        fwd_data_d = fwd_valid ? young.data : fwd_data_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q      <= '0;
            skid_q     <= '0;
            cnt_q      <= '0;
            fwd_addr_q <= '0;
            fwd_data_q <= '0;
        end else begin
            out_q      <= out_d;
            skid_q     <= skid_d;
            cnt_q      <= cnt_d;
            fwd_addr_q <= fwd_addr_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    assign in_ready     = ~skid_q.valid;
    assign rf_we        = out_q.valid & out_q.we;
    assign rf_waddr     = out_q.rd;
    assign rf_wdata     = out_q.data;
    assign fwd_addr     = fwd_addr_d;
    assign fwd_data     = fwd_data_d;
    assign retire_count = cnt_q;

endmodule

// File: tb/tb_wb_stage_buf.sv
// Scoreboard bench for wb_stage_buf: accepted writes are queued with a
// reference result and matched against register-file writes in order.
module tb_wb_stage_buf;

    localparam int DW = 16;
    localparam int AW = 3;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_wb_sel;
    logic [DW-1:0] in_alu, in_mem, in_link, in_imm;
    logic [1:0]    in_ld_mode;
    logic [AW-1:0] in_rd;
    logic          in_we;
    logic          flush;
    logic          rf_ready;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          fwd_valid;
    logic [AW-1:0] fwd_addr;
    logic [DW-1:0] fwd_data;
    logic [CW-1:0] retire_count;

    int n_tests = 0;
    int n_fail  = 0;
    int n_acc   = 0;
    int n_drop  = 0;

    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] obs_q[$];

    wb_stage_buf #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_wb_sel(in_wb_sel), .in_alu(in_alu), .in_mem(in_mem),
        .in_link(in_link), .in_imm(in_imm), .in_ld_mode(in_ld_mode),
        .in_rd(in_rd), .in_we(in_we), .flush(flush),
        .rf_ready(rf_ready), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr),
        .fwd_data(fwd_data), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] model(input logic [1:0] sel,
        input logic [DW-1:0] a, m, l, i, input logic [1:0] ld);
        case (sel)
            2'd0: return a;
            2'd1: begin
                if (ld == 2'd1) return {{8{m[7]}}, m[7:0]};
                if (ld == 2'd2) return {8'h00, m[7:0]};
                return m;
            end
            2'd2: return l;
            default: return i;
        endcase
    endfunction

    function automatic logic [CW-1:0] exp_cnt();
        return CW'(n_acc - n_drop);
    endfunction

    // one clock: observe handshakes mid-cycle, then step past the edge
    task automatic cycle();
        @(negedge clk);
        if (reset) begin
            if (in_valid && in_ready && !flush) begin
                n_acc++;
                if (in_we && in_rd != '0)
                    exp_q.push_back({in_rd, model(in_wb_sel, in_alu, in_mem,
                                                  in_link, in_imm, in_ld_mode)});
            end
            if (rf_we && rf_ready) obs_q.push_back({rf_waddr, rf_wdata});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [1:0] sel, input logic [DW-1:0] d,
                          input logic [1:0] ld, input logic [AW-1:0] rd,
                          input logic we);
        in_wb_sel  = sel;
        in_alu     = (sel == 2'd0) ? d : d ^ 16'h1111;
        in_mem     = (sel == 2'd1) ? d : d ^ 16'h2222;
        in_link    = (sel == 2'd2) ? d : d ^ 16'h4444;
        in_imm     = (sel == 2'd3) ? d : d ^ 16'h8888;
        in_ld_mode = ld;
        in_rd      = rd;
        in_we      = we;
        in_valid   = 1'b1;
    endtask

    task automatic send(input logic [1:0] sel, input logic [DW-1:0] d,
                        input logic [1:0] ld, input logic [AW-1:0] rd,
                        input logic we);
        int g;
        set_in(sel, d, ld, rd, we);
        g = 0;
        while (!in_ready && g < 50) begin
            cycle();
            g++;
        end
        n_tests++;
        if (g >= 50) begin
            n_fail++;
            $display("FAIL send_timeout: in_ready stuck at %b, expected 1", in_ready);
        end
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        n_tests += 8;
        if (rf_we !== 1'b0) begin n_fail++; $display("FAIL rst_rf_we: got %b expected 0", rf_we); end
        if (rf_waddr !== '0) begin n_fail++; $display("FAIL rst_waddr: got %h expected 0", rf_waddr); end
        if (rf_wdata !== '0) begin n_fail++; $display("FAIL rst_wdata: got %h expected 0", rf_wdata); end
        if (fwd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_fwd_valid: got %b expected 0", fwd_valid); end
        if (fwd_addr !== '0) begin n_fail++; $display("FAIL rst_fwd_addr: got %h expected 0", fwd_addr); end
        if (fwd_data !== '0) begin n_fail++; $display("FAIL rst_fwd_data: got %h expected 0", fwd_data); end
        if (retire_count !== '0) begin n_fail++; $display("FAIL rst_count: got %h expected 0", retire_count); end
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_alu();
        logic [AW+DW-1:0] e, o;
        rf_ready = 1'b1;
        send(2'd0, 16'h1234, 2'd0, 3'd3, 1'b1);
        n_tests += 4;
        if (rf_we !== 1'b1) begin n_fail++; $display("FAIL alu_rf_we: got %b expected 1", rf_we); end
        if (rf_waddr !== 3'd3) begin n_fail++; $display("FAIL alu_waddr: got %h expected 3", rf_waddr); end
        if (rf_wdata !== 16'h1234) begin n_fail++; $display("FAIL alu_wdata: got %h expected 1234", rf_wdata); end
        if (fwd_addr !== 3'd3) begin n_fail++; $display("FAIL alu_fwd_addr: got %h expected 3", fwd_addr); end
        cycle();
        n_tests++;
        if (retire_count !== exp_cnt()) begin
            n_fail++;
            $display("FAIL alu_count: got %h expected %h", retire_count, exp_cnt());
        end
        n_tests++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL alu_nwrites: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL alu_write: got %h expected %h", o, e); end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_ldext();
        logic [AW+DW-1:0] e, o;
        rf_ready = 1'b1;
        send(2'd1, 16'h00F0, 2'd1, 3'd1, 1'b1);
        n_tests++;
        if (rf_wdata !== 16'hFFF0) begin n_fail++; $display("FAIL ld_sext: got %h expected fff0", rf_wdata); end
        send(2'd1, 16'h00F0, 2'd2, 3'd2, 1'b1);
        n_tests++;
        if (rf_wdata !== 16'h00F0) begin n_fail++; $display("FAIL ld_zext: got %h expected 00f0", rf_wdata); end
        send(2'd1, 16'h00F0, 2'd3, 3'd3, 1'b1);
        n_tests++;
        if (rf_wdata !== 16'h00F0) begin n_fail++; $display("FAIL ld_mode3: got %h expected 00f0", rf_wdata); end
        send(2'd1, 16'hA5F0, 2'd0, 3'd4, 1'b1);
        send(2'd0, 16'h0080, 2'd1, 3'd5, 1'b1);
        send(2'd2, 16'h4321, 2'd1, 3'd6, 1'b1);
        send(2'd3, 16'h0077, 2'd2, 3'd7, 1'b1);
        cycle();
        cycle();
        n_tests++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL ld_nwrites: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL ld_write: got %h expected %h", o, e); end
        end
        exp_q.delete();
        obs_q.delete();
        n_tests++;
        if (retire_count !== exp_cnt()) begin
            n_fail++;
            $display("FAIL ld_count: got %h expected %h", retire_count, exp_cnt());
        end
    endtask

    task automatic test_backpressure();
        logic [AW+DW-1:0] e, o;
        rf_ready = 1'b0;
        send(2'd0, 16'h0A0A, 2'd0, 3'd1, 1'b1);
        send(2'd0, 16'h0B0B, 2'd0, 3'd2, 1'b1);
        set_in(2'd0, 16'h0C0C, 2'd0, 3'd4, 1'b1);
        repeat (3) cycle();
        n_tests += 7;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
        if (fwd_valid !== 1'b1) begin n_fail++; $display("FAIL bp_fwd_valid: got %b expected 1", fwd_valid); end
        if (fwd_addr !== 3'd2) begin n_fail++; $display("FAIL bp_fwd_addr: got %h expected 2", fwd_addr); end
        if (fwd_data !== 16'h0B0B) begin n_fail++; $display("FAIL bp_fwd_data: got %h expected 0b0b", fwd_data); end
        if (rf_we !== 1'b1) begin n_fail++; $display("FAIL bp_rf_we: got %b expected 1", rf_we); end
        if (rf_waddr !== 3'd1) begin n_fail++; $display("FAIL bp_waddr: got %h expected 1", rf_waddr); end
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL bp_early_write: got %0d writes expected 0", obs_q.size()); end
        rf_ready = 1'b1;
        send(2'd0, 16'h0C0C, 2'd0, 3'd4, 1'b1);
        repeat (3) cycle();
        n_tests++;
        if (obs_q.size() != 3 || exp_q.size() != 3) begin
            n_fail++;
            $display("FAIL bp_nwrites: got %0d expected 3", obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL bp_order: got %h expected %h", o, e); end
        end
        exp_q.delete();
        obs_q.delete();
        n_tests++;
        if (retire_count !== exp_cnt()) begin
            n_fail++;
            $display("FAIL bp_count: got %h expected %h", retire_count, exp_cnt());
        end
    endtask

    task automatic test_r0();
        rf_ready = 1'b1;
        send(2'd0, 16'h5555, 2'd0, 3'd0, 1'b1);
        n_tests += 2;
        if (rf_we !== 1'b0) begin n_fail++; $display("FAIL r0_rf_we: got %b expected 0", rf_we); end
        if (fwd_valid !== 1'b0) begin n_fail++; $display("FAIL r0_fwd_valid: got %b expected 0", fwd_valid); end
        cycle();
        n_tests += 2;
        if (retire_count !== exp_cnt()) begin
            n_fail++;
            $display("FAIL r0_count: got %h expected %h", retire_count, exp_cnt());
        end
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL r0_write: got %0d writes expected 0", obs_q.size()); end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_flush();
        logic [AW+DW-1:0] e, o;
        rf_ready = 1'b0;
        send(2'd0, 16'h0505, 2'd0, 3'd5, 1'b1);
        send(2'd0, 16'h0606, 2'd0, 3'd6, 1'b1);
        set_in(2'd0, 16'h0707, 2'd0, 3'd7, 1'b1);
        flush    = 1'b1;
        rf_ready = 1'b1;
        n_tests += 2;
        if (rf_we !== 1'b1) begin n_fail++; $display("FAIL fl_rf_we: got %b expected 1", rf_we); end
        if (rf_waddr !== 3'd5) begin n_fail++; $display("FAIL fl_waddr: got %h expected 5", rf_waddr); end
        cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        void'(exp_q.pop_back());
        n_drop++;
        n_tests += 4;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fl_in_ready: got %b expected 1", in_ready); end
        if (rf_we !== 1'b0) begin n_fail++; $display("FAIL fl_empty: got rf_we %b expected 0", rf_we); end
        if (fwd_valid !== 1'b0) begin n_fail++; $display("FAIL fl_fwd: got %b expected 0", fwd_valid); end
        if (retire_count !== exp_cnt()) begin
            n_fail++;
            $display("FAIL fl_count: got %h expected %h", retire_count, exp_cnt());
        end
        rf_ready = 1'b0;
        send(2'd0, 16'h0101, 2'd0, 3'd1, 1'b1);
        set_in(2'd0, 16'h0202, 2'd0, 3'd2, 1'b1);
        flush = 1'b1;
        cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        void'(exp_q.pop_back());
        n_drop++;
        rf_ready = 1'b1;
        repeat (2) cycle();
        n_tests += 2;
        if (rf_we !== 1'b0) begin n_fail++; $display("FAIL fl_drop_in: got rf_we %b expected 0", rf_we); end
        if (retire_count !== exp_cnt()) begin
            n_fail++;
            $display("FAIL fl_count2: got %h expected %h", retire_count, exp_cnt());
        end
        n_tests++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL fl_nwrites: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL fl_write: got %h expected %h", o, e); end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_async_reset_wrap();
        rf_ready = 1'b1;
        set_in(2'd0, 16'h7777, 2'd0, 3'd3, 1'b1);
        repeat (2) cycle();
        #3 reset = 1'b0;
        #1;
        n_tests += 6;
        if (rf_we !== 1'b0) begin n_fail++; $display("FAIL ar_rf_we: got %b expected 0", rf_we); end
        if (rf_waddr !== '0) begin n_fail++; $display("FAIL ar_waddr: got %h expected 0", rf_waddr); end
        if (rf_wdata !== '0) begin n_fail++; $display("FAIL ar_wdata: got %h expected 0", rf_wdata); end
        if (fwd_valid !== 1'b0 || fwd_addr !== '0 || fwd_data !== '0) begin
            n_fail++;
            $display("FAIL ar_fwd: got %b/%h/%h expected 0/0/0", fwd_valid, fwd_addr, fwd_data);
        end
        if (retire_count !== '0) begin n_fail++; $display("FAIL ar_count: got %h expected 0", retire_count); end
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ar_in_ready: got %b expected 1", in_ready); end
        in_valid = 1'b0;
        cycle();
        reset = 1'b1;
        n_acc  = 0;
        n_drop = 0;
        exp_q.delete();
        obs_q.delete();
        set_in(2'd0, 16'h0000, 2'd0, 3'd0, 1'b0);
        repeat (65535) cycle();
        in_valid = 1'b0;
        repeat (2) cycle();
        n_tests += 2;
        if (retire_count !== exp_cnt()) begin
            n_fail++;
            $display("FAIL wrap_pre: got %h expected %h", retire_count, exp_cnt());
        end
        if (retire_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_ffff: got %h expected ffff", retire_count); end
        send(2'd0, 16'h0000, 2'd0, 3'd0, 1'b0);
        cycle();
        n_tests += 2;
        if (retire_count !== exp_cnt()) begin
            n_fail++;
            $display("FAIL wrap_post: got %h expected %h", retire_count, exp_cnt());
        end
        if (retire_count !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero: got %h expected 0000", retire_count); end
    endtask

    initial begin
        reset      = 1'b0;
        in_valid   = 1'b0;
        in_wb_sel  = 2'd0;
        in_alu     = '0;
        in_mem     = '0;
        in_link    = '0;
        in_imm     = '0;
        in_ld_mode = 2'd0;
        in_rd      = '0;
        in_we      = 1'b0;
        flush      = 1'b0;
        rf_ready   = 1'b0;
        #12;
        test_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        test_alu();
        test_ldext();
        test_backpressure();
        test_r0();
        test_flush();
        test_async_reset_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
